countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have one clock, `clk`, and one synchronous, active-high reset, `reset`.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `tick` in 1: one-cycle decrement enable, nominally 1 Hz.
- `load` in 1: load the preset value.
- `ld_m10` in 4: preset minutes tens, BCD 0-9.
- `ld_m1` in 4: preset minutes ones, BCD 0-9.
- `ld_s10` in 4: preset seconds tens, BCD 0-5.
- `ld_s1` in 4: preset seconds ones, BCD 0-9.
- `start` in 1: begin or resume counting.
- `stop` in 1: pause counting.
- `m10` out 4: current minutes tens digit.
- `m1` out 4: current minutes ones digit.
- `s10` out 4: current seconds tens digit.
- `s1` out 4: current seconds ones digit.
- `running` out 1: high while in state RUN.
- `done` out 1: one-cycle expiry pulse.
- `load_err` out 1: one-cycle pulse when a load is rejected.

Function
REQ-003 The block SHALL be a BCD MM:SS down-counter: a cascade of digits s1 (mod 10), s10 (mod 6), m1 (mod 10) and m10 (mod 10), each propagating a borrow to the next digit up.
REQ-004 The FSM SHALL have the states IDLE, RUN, PAUSED and EXPIRED.
REQ-005 All outputs and state SHALL register on the rising edge of `clk`; no output SHALL have a combinational path from any input.
REQ-006 Per-cycle control priority SHALL be: reset > load > stop > start > tick.
REQ-007 Load SHALL be accepted in IDLE, PAUSED and EXPIRED only:
- digits are copied on the same edge;
- the next state is IDLE.
REQ-008 Load SHALL be rejected when any digit is out of range (`ld_s10`>5, or any other digit >9):
- the count and state are unchanged;
- `load_err` = 1 for one cycle.
REQ-009 Load asserted in RUN SHALL be ignored silently (no `load_err`).
REQ-010 `start` in IDLE or PAUSED with a count not equal to 00:00 SHALL move the FSM to RUN.
REQ-011 `start` with a count of 00:00, or in EXPIRED, SHALL be ignored.
REQ-012 `stop` in RUN SHALL move the FSM to PAUSED; `stop` in any other state SHALL be ignored.
REQ-013 `tick` SHALL decrement the count only in RUN, and only in a cycle where `load` and `stop` are low.
REQ-014 `tick` in the same cycle as the IDLE/PAUSED-to-RUN transition SHALL NOT decrement.
REQ-015 Per-digit decrement rules:
- s1: if 0, s1→9 and borrow; else s1−1.
- s10 on borrow: if 0, s10→5 and borrow; else s10−1.
- m1 on borrow: if 0, m1→9 and borrow; else m1−1.
- m10 on borrow: m10−1.
- m10 is never 0 when it receives a borrow.
REQ-016 Example decrements: 10:00→09:59 and 01:00→00:59 in one tick.
REQ-017 A tick in RUN with count 00:01 SHALL, on that same edge:
- set the count to 00:00;
- set `done` = 1 (high for exactly one cycle);
- move the state to EXPIRED.
REQ-018 In EXPIRED the count SHALL hold at 00:00 and ticks SHALL be ignored until a valid load.
REQ-019 `running` SHALL be 1 exactly when the state is RUN.
REQ-020 Digit outputs SHALL always be valid BCD: s10≤5, all other digits ≤9, under any input sequence.
REQ-021 99:59 SHALL be the maximum count; there SHALL be no wrap above it and no underflow below 00:00.

Reset
REQ-022 With `reset` = 1 at a clock edge, the block SHALL set:
- state = IDLE;
- all digits = 0;
- `running` = 0, `done` = 0, `load_err` = 0.
REQ-023 Reset SHALL override every other input in the same cycle, including a reset asserted mid-count in RUN.
REQ-024 There SHALL be no asynchronous behaviour.

Verification
REQ-025 Basic expiry: load 00:03, start, then 3 ticks → 00:02, 00:01, 00:00. `done` pulses once, aligned with 00:00; state EXPIRED; `running` = 0.
REQ-026 Borrow chain: load 10:00, start, 1 tick → 09:59. Load 00:10 → after 1 tick, 00:09. Load 01:00 → after 1 tick, 00:59.
REQ-027 Pause/resume: in RUN at 05:30, `stop` with `tick` in the same cycle → 05:30 held. Ticks while PAUSED → no change. `start`, then tick → 05:29.
REQ-028 Bad load: `ld_s10` = 6 in IDLE → `load_err` pulse, count unchanged. Load asserted in RUN → ignored, no `load_err`.
REQ-029 Edge starts: `start` at 00:00 → stays IDLE. `start` + `tick` in the same cycle from IDLE at 00:05 → RUN, count still 00:05.
REQ-030 Reset mid-run: at 12:34 in RUN, assert `reset` together with `tick` → 00:00, IDLE, all flags 0.

Source files
------------

// File: rtl/countdown_timer.sv
// BCD MM:SS countdown timer with load/start/stop control.
// Digits cascade s1 -> s10 -> m1 -> m10 through a borrow chain; expiry pulses done.
module countdown_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] ld_m10,
    input  logic [3:0] ld_m1,
    input  logic [3:0] ld_s10,
    input  logic [3:0] ld_s1,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] m10,
    output logic [3:0] m1,
    output logic [3:0] s10,
    output logic [3:0] s1,
    output logic       running,
    output logic       done,
    output logic       load_err
);

    // state   | meaning
    // IDLE    | loaded or reset, waiting for start
    // RUN     | counting down on tick
    // PAUSED  | stopped mid-count, resumable
    // EXPIRED | reached 00:00, only a valid load leaves
    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    state_t     state_q, state_d;
    logic [3:0] m10_q, m1_q, s10_q, s1_q;
    logic [3:0] m10_d, m1_d, s10_d, s1_d;
    logic [3:0] m10_dec, m1_dec, s10_dec, s1_dec;
    logic       done_q, done_d;
    logic       load_err_q, load_err_d;
    logic       b1, b2, b3;
    logic       count_zero, count_one, load_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            m10_q      <= 4'd0;
            m1_q       <= 4'd0;
            s10_q      <= 4'd0;
            s1_q       <= 4'd0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            m10_q      <= m10_d;
            m1_q       <= m1_d;
            s10_q      <= s10_d;
            s1_q       <= s1_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    // One-tick decrement of the current count through the borrow chain.
    always_comb begin
        b1      = (s1_q == 4'd0);
        s1_dec  = b1 ? 4'd9 : s1_q - 4'd1;
        b2      = b1 && (s10_q == 4'd0);
        s10_dec = b1 ? ((s10_q == 4'd0) ? 4'd5 : s10_q - 4'd1) : s10_q;
        b3      = b2 && (m1_q == 4'd0);
        m1_dec  = b2 ? ((m1_q == 4'd0) ? 4'd9 : m1_q - 4'd1) : m1_q;
        m10_dec = b3 ? m10_q - 4'd1 : m10_q;
    end

    always_comb begin
        count_zero = (m10_q == 4'd0) && (m1_q == 4'd0) && (s10_q == 4'd0) && (s1_q == 4'd0);
        count_one  = (m10_q == 4'd0) && (m1_q == 4'd0) && (s10_q == 4'd0) && (s1_q == 4'd1);
        load_ok    = (ld_m10 <= 4'd9) && (ld_m1 <= 4'd9) && (ld_s10 <= 4'd5) && (ld_s1 <= 4'd9);

        state_d    = state_q;
        m10_d      = m10_q;
        m1_d       = m1_q;
        s10_d      = s10_q;
        s1_d       = s1_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;

        // A load in RUN outranks stop/start/tick, so the whole cycle is a no-op.
        if (load) begin
            if (state_q != RUN) begin
                if (load_ok) begin
                    m10_d   = ld_m10;
                    m1_d    = ld_m1;
                    s10_d   = ld_s10;
                    s1_d    = ld_s1;
                    state_d = IDLE;
                end else begin
                    load_err_d = 1'b1;
                end
            end
        end else if (stop) begin
            if (state_q == RUN) state_d = PAUSED;
        end else if (start && (state_q == IDLE || state_q == PAUSED) && !count_zero) begin
            state_d = RUN;
        end else if (tick && state_q == RUN && !count_zero) begin
            m10_d = m10_dec;
            m1_d  = m1_dec;
            s10_d = s10_dec;
            s1_d  = s1_dec;
            if (count_one) begin
                done_d  = 1'b1;
                state_d = EXPIRED;
            end
        end
    end

    always_comb begin
        running  = (state_q == RUN);
        done     = done_q;
        load_err = load_err_q;
        m10      = m10_q;
        m1       = m1_q;
        s10      = s10_q;
        s1       = s1_q;
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed vector table plus random stimulus against a seconds-based reference model.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b0, tick = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0;
    logic [3:0] ld_m10 = '0, ld_m1 = '0, ld_s10 = '0, ld_s1 = '0;
    logic [3:0] m10, m1, s10, s1;
    logic       running, done, load_err;

    int n_checks = 0;
    int n_fail   = 0;

    countdown_timer dut (
        .clk(clk), .reset(reset), .tick(tick), .load(load),
        .ld_m10(ld_m10), .ld_m1(ld_m1), .ld_s10(ld_s10), .ld_s1(ld_s1),
        .start(start), .stop(stop),
        .m10(m10), .m1(m1), .s10(s10), .s1(s1),
        .running(running), .done(done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          ld;
        logic [15:0] ldv;
        bit          st;
        bit          sp;
        bit          tk;
        logic [15:0] exp_cnt;
        bit          exp_run;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit ld, logic [15:0] ldv, bit st, bit sp, bit tk,
                                logic [15:0] ec, bit er, bit ed, bit ee);
        vec_t v;
        v.rst = rst; v.ld = ld; v.ldv = ldv; v.st = st; v.sp = sp; v.tk = tk;
        v.exp_cnt = ec; v.exp_run = er; v.exp_done = ed; v.exp_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit ld, input logic [15:0] v,
                         input bit st, input bit sp, input bit tk);
        @(negedge clk);
        reset = r; load = ld; start = st; stop = sp; tick = tk;
        ld_m10 = v[15:12]; ld_m1 = v[11:8]; ld_s10 = v[7:4]; ld_s1 = v[3:0];
        @(posedge clk);
        #1;
    endtask

    // Reference model: count in whole seconds, state as a small integer.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;
    int mcnt = 0;
    int mstate = M_IDLE;
    bit mdone = 0, merr = 0;

    function automatic logic [15:0] to_bcd(input int secs);
        int mins, ss;
        logic [15:0] r;
        mins = secs / 60;
        ss   = secs % 60;
        r[15:12] = 4'(mins / 10);
        r[11:8]  = 4'(mins % 10);
        r[7:4]   = 4'(ss / 10);
        r[3:0]   = 4'(ss % 10);
        return r;
    endfunction

    task automatic model_step(input bit r, input bit ld, input logic [15:0] v,
                              input bit st, input bit sp, input bit tk);
        mdone = 0;
        merr  = 0;
        if (r) begin
            mcnt = 0;
            mstate = M_IDLE;
        end else if (ld) begin
            if (mstate != M_RUN) begin
                if (v[15:12] <= 9 && v[11:8] <= 9 && v[7:4] <= 5 && v[3:0] <= 9) begin
                    mcnt = int'(v[15:12]) * 600 + int'(v[11:8]) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
                    mstate = M_IDLE;
                end else begin
                    merr = 1;
                end
            end
        end else if (sp) begin
            if (mstate == M_RUN) mstate = M_PAUSED;
        end else if (st && (mstate == M_IDLE || mstate == M_PAUSED) && mcnt != 0) begin
            mstate = M_RUN;
        end else if (tk && mstate == M_RUN) begin
            mcnt = mcnt - 1;
            if (mcnt == 0) begin
                mdone = 1;
                mstate = M_EXP;
            end
        end
    endtask

    initial begin
        // rst ld ldv st sp tk | count run done err
        vecs.push_back(mk(1,0,16'h0000,0,0,0, 16'h0000,0,0,0));
        // basic expiry
        vecs.push_back(mk(0,1,16'h0003,0,0,0, 16'h0003,0,0,0));
        vecs.push_back(mk(0,0,16'h0000,1,0,0, 16'h0003,1,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,1, 16'h0002,1,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,1, 16'h0001,1,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,1, 16'h0000,0,1,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,1, 16'h0000,0,0,0));
        vecs.push_back(mk(0,0,16'h0000,1,0,0, 16'h0000,0,0,0));
        // borrow chain
        vecs.push_back(mk(0,1,16'h1000,0,0,0, 16'h1000,0,0,0));
        vecs.push_back(mk(0,0,16'h0000,1,0,0, 16'h1000,1,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,1, 16'h0959,1,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,1,0, 16'h0959,0,0,0));
        vecs.push_back(mk(0,1,16'h0010,0,0,0, 16'h0010,0,0,0));
        vecs.push_back(mk(0,0,16'h0000,1,0,0, 16'h0010,1,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,1, 16'h0009,1,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,1,0, 16'h0009,0,0,0));
        vecs.push_back(mk(0,1,16'h0100,0,0,0, 16'h0100,0,0,0));
        vecs.push_back(mk(0,0,16'h0000,1,0,0, 16'h0100,1,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,1, 16'h0059,1,0,0));
        // maximum count
        vecs.push_back(mk(0,0,16'h0000,0,1,0, 16'h0059,0,0,0));
        vecs.push_back(mk(0,1,16'h9959,0,0,0, 16'h9959,0,0,0));
        vecs.push_back(mk(0,0,16'h0000,1,0,0, 16'h9959,1,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,1, 16'h9958,1,0,0));
        // pause / resume
        vecs.push_back(mk(0,0,16'h0000,0,1,0, 16'h9958,0,0,0));
        vecs.push_back(mk(0,1,16'h0530,0,0,0, 16'h0530,0,0,0));
        vecs.push_back(mk(0,0,16'h0000,1,0,0, 16'h0530,1,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,1,1, 16'h0530,0,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,1, 16'h0530,0,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,1, 16'h0530,0,0,0));
        vecs.push_back(mk(0,0,16'h0000,1,0,0, 16'h0530,1,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,1, 16'h0529,1,0,0));
        // bad loads and load in RUN
        vecs.push_back(mk(0,0,16'h0000,0,1,0, 16'h0529,0,0,0));
        vecs.push_back(mk(0,1,16'h0100,0,0,0, 16'h0100,0,0,0));
        vecs.push_back(mk(0,1,16'h0160,0,0,0, 16'h0100,0,0,1));
        vecs.push_back(mk(0,0,16'h0000,0,0,0, 16'h0100,0,0,0));
        vecs.push_back(mk(0,1,16'hA000,0,0,0, 16'h0100,0,0,1));
        vecs.push_back(mk(0,0,16'h0000,1,0,0, 16'h0100,1,0,0));
        vecs.push_back(mk(0,1,16'h0200,0,0,0, 16'h0100,1,0,0));
        vecs.push_back(mk(0,1,16'h0200,0,0,1, 16'h0100,1,0,0));
        // edge starts
        vecs.push_back(mk(0,0,16'h0000,0,1,0, 16'h0100,0,0,0));
        vecs.push_back(mk(0,1,16'h0000,0,0,0, 16'h0000,0,0,0));
        vecs.push_back(mk(0,0,16'h0000,1,0,0, 16'h0000,0,0,0));
        vecs.push_back(mk(0,1,16'h0005,0,0,0, 16'h0005,0,0,0));
        vecs.push_back(mk(0,0,16'h0000,1,0,1, 16'h0005,1,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,1, 16'h0004,1,0,0));
        // reset mid-run
        vecs.push_back(mk(0,0,16'h0000,0,1,0, 16'h0004,0,0,0));
        vecs.push_back(mk(0,1,16'h1234,0,0,0, 16'h1234,0,0,0));
        vecs.push_back(mk(0,0,16'h0000,1,0,0, 16'h1234,1,0,0));
        vecs.push_back(mk(1,0,16'h0000,0,0,1, 16'h0000,0,0,0));
        vecs.push_back(mk(0,0,16'h0000,0,0,1, 16'h0000,0,0,0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].ld, vecs[i].ldv, vecs[i].st, vecs[i].sp, vecs[i].tk);
            check($sformatf("vec%0d count", i), {m10, m1, s10, s1}, vecs[i].exp_cnt);
            check($sformatf("vec%0d running", i), 16'(running), 16'(vecs[i].exp_run));
            check($sformatf("vec%0d done", i), 16'(done), 16'(vecs[i].exp_done));
            check($sformatf("vec%0d load_err", i), 16'(load_err), 16'(vecs[i].exp_err));
        end

        // Random phase: start from reset so model and DUT agree.
        drive(1, 0, 16'h0000, 0, 0, 0);
        model_step(1, 0, 16'h0000, 0, 0, 0);
        for (int c = 0; c < 4000; c++) begin
            bit r, ld, st, sp, tk;
            logic [15:0] v;
            r  = ($urandom_range(127) == 0);
            ld = ($urandom_range(9) == 0);
            st = ($urandom_range(3) == 0);
            sp = ($urandom_range(11) == 0);
            tk = ($urandom_range(1) == 0);
            if ($urandom_range(3) == 0) begin
                v = 16'($urandom_range(65535));
            end else if ($urandom_range(1) == 0) begin
                v = {8'h00, 4'($urandom_range(1)), 4'($urandom_range(9))};
            end else begin
                v = {4'($urandom_range(9)), 4'($urandom_range(9)),
                     4'($urandom_range(5)), 4'($urandom_range(9))};
            end
            drive(r, ld, v, st, sp, tk);
            model_step(r, ld, v, st, sp, tk);
            check($sformatf("rnd%0d count", c), {m10, m1, s10, s1}, to_bcd(mcnt));
            check($sformatf("rnd%0d running", c), 16'(running), 16'(mstate == M_RUN));
            check($sformatf("rnd%0d done", c), 16'(done), 16'(mdone));
            check($sformatf("rnd%0d load_err", c), 16'(load_err), 16'(merr));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
